// File: rtl/pitchrise_pkg.sv
// Shared types and constants for the pitchrise upward pitch-glide generator.
package pitchrise_pkg;

  localparam int TIMER_W           = 26;
  localparam int NOTE_W            = 7;
  localparam int SPEED_W           = 4;
  localparam int DEPTH_MAX_DEFAULT = 24;

  localparam logic [TIMER_W-1:0] TIMER_THRESH = 26'd2097120;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    HOLD
  } state_t;

  // Note minus offset, clamped at the bottom of the MIDI range.
  function automatic logic [NOTE_W-1:0] floor_sub(input logic [NOTE_W-1:0] a,
                                                  input logic [NOTE_W-1:0] b);
    return (a >= b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/pitchrise_if.sv
// Control/status bundle between the voice path and the pitchrise glide block.
interface pitchrise_if;
  import pitchrise_pkg::*;

  logic               en;
  logic [SPEED_W-1:0] speed;
  logic [NOTE_W-1:0]  depth;
  logic               note_on;
  logic               note_repeat;
  logic [NOTE_W-1:0]  note_start;
  logic [NOTE_W-1:0]  rise_offset;
  logic [NOTE_W-1:0]  pitch_out;
  logic [3:0]         rise_fine;
  logic               active;
  logic               done;

  modport master (
    output en, speed, depth, note_on, note_repeat, note_start,
    input  rise_offset, pitch_out, rise_fine, active, done
  );

  modport slave (
    input  en, speed, depth, note_on, note_repeat, note_start,
    output rise_offset, pitch_out, rise_fine, active, done
  );

endinterface

// File: rtl/pitchrise_rise_timer.sv
// Step prescaler: accumulates 1<<speed per enabled cycle and ticks once the
// registered count passes TIMER_THRESH, then restarts from 1.
module rise_timer
  import pitchrise_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear,
  input  logic               run,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick,
  output logic [3:0]         phase
);

  logic [TIMER_W-1:0] timer_reg;
  logic [TIMER_W-1:0] timer_next;

  assign tick  = run & (timer_reg > TIMER_THRESH);
  assign phase = timer_reg[20:17];

  always_comb begin
    timer_next = timer_reg;
    if (en) begin
      if (clear || tick) begin
        timer_next = TIMER_W'(1);
      end else if (run) begin
        timer_next = timer_reg + (TIMER_W'(1) << speed);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reg <= TIMER_W'(1);
    end else begin
      timer_reg <= timer_next;
    end
  end

endmodule

// File: rtl/pitchrise.sv
// Upward pitch glide: starts a note up to MAX_DEPTH semitones low and climbs to it.
// Optional PITCHRISE_FINE_EN exposes the sub-semitone phase on rise_fine.
module pitchrise
  import pitchrise_pkg::*;
#(
  parameter int MAX_DEPTH = DEPTH_MAX_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  pitchrise_if.slave bus
);

  state_t            state_reg, state_next;
  logic [NOTE_W-1:0] note_reg, note_next;
  logic [NOTE_W-1:0] offset_reg, offset_next;
  logic              repeat_reg, repeat_next;
  logic              done_reg, done_next;

  logic [NOTE_W-1:0] depth_clamped;
  logic              note_differs;
  logic              trigger;
  logic              retrig;
  logic              run;
  logic              tick;
  logic [3:0]        phase;

  assign depth_clamped = (int'(bus.depth) > MAX_DEPTH) ? NOTE_W'(MAX_DEPTH) : bus.depth;
  assign note_differs  = (bus.note_start != note_reg);
  assign trigger       = bus.en & bus.note_on & (state_reg == IDLE) & (note_differs | repeat_reg);
  assign retrig        = note_differs | bus.note_repeat;
  // Release and retrigger outrank a step, so the timer only advances when neither applies.
  assign run           = bus.note_on & (state_reg == RISE) & ~retrig;

  rise_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clear (trigger),
    .run   (run),
    .speed (bus.speed),
    .tick  (tick),
    .phase (phase)
  );

  always_comb begin
    state_next  = state_reg;
    note_next   = note_reg;
    offset_next = offset_reg;
    repeat_next = repeat_reg;
    done_next   = 1'b0;

    if (bus.en) begin
      if (!bus.note_on) begin
        state_next  = IDLE;
        offset_next = '0;
        note_next   = '0;
        if (!note_differs) begin
          repeat_next = bus.note_repeat;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (trigger) begin
              note_next   = bus.note_start;
              offset_next = depth_clamped;
              repeat_next = 1'b0;
              if (depth_clamped == '0) begin
                state_next = HOLD;
                done_next  = 1'b1;
              end else begin
                state_next = RISE;
              end
            end
          end
          RISE: begin
            if (retrig) begin
              state_next  = IDLE;
              repeat_next = bus.note_repeat;
            end else if (tick) begin
              offset_next = offset_reg - NOTE_W'(1);
              if (offset_reg == NOTE_W'(1)) begin
                state_next = HOLD;
                done_next  = 1'b1;
              end
            end
          end
          HOLD: begin
            if (retrig) begin
              state_next  = IDLE;
              repeat_next = bus.note_repeat;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      note_reg   <= '0;
      offset_reg <= '0;
      repeat_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      note_reg   <= note_next;
      offset_reg <= offset_next;
      repeat_reg <= repeat_next;
      done_reg   <= done_next;
    end
  end

  assign bus.rise_offset = offset_reg;
  assign bus.pitch_out   = floor_sub(note_reg, offset_reg);
  assign bus.active      = (state_reg == RISE);
  assign bus.done        = done_reg;

`ifdef PITCHRISE_FINE_EN
  assign bus.rise_fine = (state_reg == RISE) ? 4'd15 - phase : 4'd0;
`else
  assign bus.rise_fine = phase & 4'd0;
`endif

endmodule

// File: tb/tb_pitchrise.sv
// Scoreboard bench for pitchrise: a cycle-level reference model queues expected
// outputs, a negedge monitor pops and compares them.
module tb_pitchrise;

  localparam int MAXD   = 24;
  localparam int THRESH = 2097120;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pitchrise_if bus();

  pitchrise #(.MAX_DEPTH(MAXD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int off;
    int pitch;
    int act;
    int dn;
    int fine;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: target note, semitones still to climb, enabled cycles since last step.
  int m_note = 0;
  int m_off  = 0;
  int m_cnt  = 0;
  bit m_rep  = 0;
  bit gliding = 0;
  bit settled = 0;

  // Enabled cycles between steps: smallest k with 1 + k*2^s > THRESH, plus one.
  function automatic int period(input int s);
    return (THRESH - 1) / (1 << s) + 2;
  endfunction

  task automatic model_edge();
    exp_t e;
    bit dn;
    int d;
    dn = 0;
    if (reset) begin
      m_note = 0; m_off = 0; m_cnt = 0; m_rep = 0; gliding = 0; settled = 0;
    end else if (!bus.en) begin
      dn = 0;
    end else if (!bus.note_on) begin
      if (int'(bus.note_start) == m_note) m_rep = bus.note_repeat;
      m_note = 0; m_off = 0; gliding = 0; settled = 0;
    end else if (!gliding && !settled) begin
      if (int'(bus.note_start) != m_note || m_rep) begin
        d = int'(bus.depth);
        m_note = int'(bus.note_start);
        m_off  = (d > MAXD) ? MAXD : d;
        m_rep  = 0;
        m_cnt  = 0;
        if (m_off == 0) begin settled = 1; dn = 1; end
        else gliding = 1;
      end
    end else if (int'(bus.note_start) != m_note || bus.note_repeat) begin
      gliding = 0; settled = 0; m_rep = bus.note_repeat;
    end else if (gliding) begin
      m_cnt++;
      if (m_cnt == period(int'(bus.speed))) begin
        m_cnt = 0;
        m_off--;
        if (m_off == 0) begin gliding = 0; settled = 1; dn = 1; end
      end
    end
    e.off   = m_off;
    e.pitch = (m_note >= m_off) ? m_note - m_off : 0;
    e.act   = int'(gliding);
    e.dn    = int'(dn);
`ifdef PITCHRISE_FINE_EN
    e.fine  = gliding ? 15 - (((1 + m_cnt * (1 << int'(bus.speed))) >> 17) & 15) : 0;
`else
    e.fine  = 0;
`endif
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int exp, input int c);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("rise_offset", int'(bus.rise_offset), mon_e.off,   mon_e.cyc);
      check("pitch_out",   int'(bus.pitch_out),   mon_e.pitch, mon_e.cyc);
      check("active",      int'(bus.active),      mon_e.act,   mon_e.cyc);
      check("done",        int'(bus.done),        mon_e.dn,    mon_e.cyc);
      check("rise_fine",   int'(bus.rise_fine),   mon_e.fine,  mon_e.cyc);
      if (mon_e.dn != 0)
        $display("glide complete cycle %0d pitch %0d", mon_e.cyc, mon_e.pitch);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    cyc++;
  endtask

  task automatic release_note(input int s);
    bus.note_on = 1'b0;
    bus.en      = 1'b1;
    bus.speed   = 4'(s);
    cycle();
  endtask

  task automatic start_note(input int n, input int d);
    bus.note_start = 7'(n);
    bus.depth      = 7'(d);
    bus.note_on    = 1'b1;
    $display("note start %0d depth %0d speed %0d at cycle %0d", n, d, int'(bus.speed), cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    $display("reset asserted at cycle %0d", cyc);
    cycle();
    reset = 1'b0;
  endtask

  int r;

  initial begin
    bus.en          = 1'b1;
    bus.speed       = 4'd15;
    bus.depth       = 7'd0;
    bus.note_on     = 1'b0;
    bus.note_repeat = 1'b0;
    bus.note_start  = 7'd0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    repeat (3) cycle();

    start_note(60, 2);
    repeat (200) cycle();

    release_note(15);
    start_note(10, 30);
    repeat (24 * 65 + 20) cycle();

    release_note(15);
    start_note(60, 3);
    repeat (80) cycle();
    bus.note_start = 7'd64;
    $display("note change to 64 at cycle %0d", cyc);
    repeat (300) cycle();

    bus.note_repeat = 1'b1;
    cycle();
    bus.note_repeat = 1'b0;
    repeat (100) cycle();
    bus.note_repeat = 1'b1;
    $display("repeat pulse mid-glide at cycle %0d", cyc);
    cycle();
    bus.note_repeat = 1'b0;
    repeat (250) cycle();

    release_note(14);
    start_note(40, 2);
    repeat (50) cycle();
    bus.en = 1'b0;
    $display("enable low for 100 cycles at cycle %0d", cyc);
    repeat (100) cycle();
    bus.en = 1'b1;
    repeat (300) cycle();

    release_note(15);
    start_note(70, 0);
    repeat (5) cycle();

    release_note(15);
    start_note(50, 8);
    repeat (3 * 65 + 5) cycle();
    do_reset();
    repeat (20) cycle();

    $display("random phase from cycle %0d", cyc);
    for (int i = 0; i < 20000; i++) begin
      r = int'($urandom_range(999));
      if (r < 3) begin
        bus.note_on     = 1'b0;
        bus.en          = 1'b1;
        bus.note_repeat = 1'b0;
        bus.speed       = 4'(13 + $urandom_range(2));
      end else begin
        bus.note_on     = 1'b1;
        bus.en          = ($urandom_range(9) != 0);
        if (r < 8) bus.note_start = 7'($urandom_range(127));
        bus.note_repeat = (r >= 8 && r < 11);
      end
      bus.depth = 7'($urandom_range(30));
      cycle();
    end

    release_note(15);
    repeat (3) cycle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pitchrise.md
# pitchrise

Upward pitch-glide generator for the Game Boy MIDI voice path, the rising counterpart of the pitch-fall effect. When a note starts, the block holds the pitch a programmable number of semitones below the target and steps it up one semitone at a time until it reaches the target. It sits between the MIDI note decoder and the channel frequency lookup. It outputs the live offset, the glided note number, status, and a completion pulse.

## Interface
- `MAX_DEPTH`, default 24: largest accepted start offset in semitones; larger `depth` values clamp to this.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: clock enable. While low, all state holds and `done` is forced low.
- `speed` in 4: rate select; the timer increment is `1 << speed`.
- `depth` in 7: start offset in semitones, sampled on trigger.
- `note_on` in 1: gate from the voice allocator.
- `note_repeat` in 1: same note re-struck; forces a retrigger.
- `note_start` in 7: target MIDI note.
- `rise_offset` out 7: semitones currently below target.
- `pitch_out` out 7: `note_reg - rise_offset`, floored at 0 (combinational from registers).
- `rise_fine` out 4: sub-semitone phase (see Configuration).
- `active` out 1: high in state RISE.
- `done` out 1: one-cycle pulse when the glide completes.

## Operation
- States are IDLE, RISE and HOLD. Reset state is IDLE. Reset values: `rise_offset`=0, `note_reg`=0, timer=1, `repeat_reg`=0, `done`=0, `active`=0.
- **Trigger condition:** `en & note_on & (state==IDLE) & ((note_start!=note_reg) | repeat_reg)`.
  - On trigger: `note_reg`←`note_start`, `rise_offset`←min(`depth`,`MAX_DEPTH`), timer←1, `repeat_reg`←0.
  - Next state is RISE. If the clamped depth is 0, next state is HOLD.
- **RISE:**
  - Each enabled cycle, timer←timer+(1<<`speed`), with 26-bit wrap-free arithmetic.
  - When the registered timer exceeds 26'd2097120: `rise_offset`←`rise_offset`−1 and timer←1.
  - When `rise_offset` goes from 1 to 0, next state is HOLD.
- **HOLD:** the offset stays at 0 and the timer is idle.
- **Retrigger from RISE or HOLD:** `note_start!=note_reg` or `note_repeat` sends the block to IDLE and captures `repeat_reg`←`note_repeat`. The trigger condition re-evaluates on the following cycle.
- **Note release:** `note_on` low sends the block to IDLE from any state.
  - It also sets `rise_offset`←0 and `note_reg`←0.
  - If `note_start==note_reg`, it sets `repeat_reg`←`note_repeat`.
- **Priority:** `reset` > `!en` hold > `note_on` low > retrigger > step.
- **`done`** is registered. It is high for exactly one cycle after RISE→HOLD, or after a trigger with depth 0.

## Timing
- The trigger is visible on `rise_offset`, `pitch_out` and `active` in the cycle after the triggering edge.
- Step period is measured from the trigger edge or the previous step. It equals the number of enabled cycles k until 1+k·2^speed>2097120, plus 1.
  - At `speed`=15 the period is 65 enabled cycles.
  - At `speed`=0 the period is 2097121 cycles.
- Cycles with `en` low do not count toward the step period.
- Release and retrigger both take effect on the next edge. A retrigger needs 2 cycles before the new glide is visible.
- `pitch_out` floors at 0 when `rise_offset` > `note_reg`.

## Configuration
- `PITCHRISE_FINE_EN` defined:
  - In RISE, `rise_fine` = 15 − timer[20:17], giving an interpolation phase for fine frequency.
  - Outside RISE, `rise_fine` = 0.
- Not defined: `rise_fine` is tied to 0 and the port remains present.

## Structure
- Package `pitchrise_pkg` holds:
  - the state enum (IDLE, RISE, HOLD);
  - `TIMER_THRESH` = 26'd2097120;
  - `DEPTH_MAX_DEFAULT` = 24;
  - `TIMER_W` = 26.
- Sub-module `rise_timer`: the 26-bit prescaler. It takes `clk`, `reset`, `en`, `clear`, `run` and `speed`, and outputs `tick` and `phase[3:0]`.

## Test plan
- Reset mid-RISE (offset 5) → next cycle offset=0, state IDLE, `done`=0, `pitch_out`=0.
- `speed`=15, `depth`=2, `note_on` with note 60 → `pitch_out` goes 58, then 59 after 65 cycles, then 60 after 130 cycles. `done` is high for one cycle after the 60 appears, then `active`=0.
- `depth`=30 (clamped to 24), note 10 → `rise_offset`=24 and `pitch_out`=0 (floor). After 14 steps, `pitch_out`=0; after 15 steps, `pitch_out`=1.
- `note_on` held, note changes 60→64 mid-RISE → offset reloads to `depth` 2 cycles later with target 64. The same note with `note_repeat` pulsed also retriggers.
- `en` low for 100 cycles mid-RISE → offset and timer frozen and `done` low. The step is delayed by exactly 100 cycles.
- `depth`=0 → HOLD directly, `pitch_out`=note, `done` pulses once. With the macro defined, `rise_fine` falls from 15 toward 0 within each RISE step.
